// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter
// Purpose  : Round-robin arbiter sharing a 6-to-1 bit mux among six
//            requesters. Grants one source at a time and drives the mux
//            select for it. Tenure is capped at MAX_HOLD cycles whenever
//            another source is waiting. The selected data bit is gated
//            onto a single output line.
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous reset, active-high
//            i_req      - request per source (bit i = source i)
//            i_release  - current owner done; ignored when idle
//            i_data_in  - data bit per source
//            o_grant    - one-hot grant, registered, zero when idle
//            o_sel      - mux select 0..5, registered
//            o_busy     - registered, high while a grant is held
//            o_data_out - i_data_in[o_sel] while busy, else 0
//            o_timeout  - one-cycle pulse when a tenure is force-ended
// Revision : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] i_req,
  input  logic       i_release,
  input  logic [5:0] i_data_in,
  output logic [5:0] o_grant,
  output logic [2:0] o_sel,
  output logic       o_busy,
  output logic       o_data_out,
  output logic       o_timeout
);

  localparam logic [HOLD_W-1:0] c_HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t            r_state;
  logic [5:0]        r_grant;
  logic [2:0]        r_sel;
  logic              r_busy;
  logic              r_timeout;
  logic [HOLD_W-1:0] r_hold;
  logic [2:0]        r_last;

  state_t            w_state_nxt;
  logic [5:0]        w_grant_nxt;
  logic [2:0]        w_sel_nxt;
  logic              w_busy_nxt;
  logic              w_timeout_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [2:0]        w_last_nxt;

  logic [5:0]        w_cand;
  logic              w_found;
  logic [2:0]        w_win;
  logic              w_norm_end;
  logic              w_force_end;

  // Index of the k-th source after base, wrapping 5 -> 0.
  function automatic logic [2:0] f_wrap(input logic [2:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= 6) s = s - 6;
    return s[2:0];
  endfunction

  // While owning, the owner is excluded so a hand-over always goes elsewhere.
  assign w_cand = (r_state == S_OWN) ? (i_req & ~r_grant) : i_req;

  // Scan from the farthest position back to the nearest so the nearest
  // pending source after r_last is the one left standing.
  always_comb begin
    w_found = 1'b0;
    w_win   = 3'd0;
    for (int k = 6; k >= 1; k--) begin
      if (w_cand[f_wrap(r_last, k)]) begin
        w_found = 1'b1;
        w_win   = f_wrap(r_last, k);
      end
    end
  end

  assign w_norm_end  = i_release || ((i_req & r_grant) == 6'b0);
  assign w_force_end = (r_hold == c_HOLD_MAX) && w_found;

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_sel_nxt     = r_sel;
    w_busy_nxt    = r_busy;
    w_hold_nxt    = r_hold;
    w_last_nxt    = r_last;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_OWN;
          w_grant_nxt = 6'(1) << w_win;
          w_sel_nxt   = w_win;
          w_busy_nxt  = 1'b1;
          w_hold_nxt  = '0;
          w_last_nxt  = w_win;
        end
      end
      S_OWN: begin
        if (w_norm_end || w_force_end) begin
          // A release on the same edge as the cap takes precedence: no pulse.
          w_timeout_nxt = !w_norm_end;
          if (w_found) begin
            w_grant_nxt = 6'(1) << w_win;
            w_sel_nxt   = w_win;
            w_hold_nxt  = '0;
            w_last_nxt  = w_win;
          end else begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = 6'b0;
            w_busy_nxt  = 1'b0;
          end
        end else if (r_hold != c_HOLD_MAX) begin
          // Saturates at the cap so a lone owner keeps the grant forever.
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_grant   <= 6'b0;
      r_sel     <= 3'd0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_hold    <= '0;
      r_last    <= 3'd5;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_sel     <= w_sel_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
      r_hold    <= w_hold_nxt;
      r_last    <= w_last_nxt;
    end
  end

  assign o_grant    = r_grant;
  assign o_sel      = r_sel;
  assign o_busy     = r_busy;
  assign o_timeout  = r_timeout;
  assign o_data_out = r_busy & i_data_in[r_sel];

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_rr_arbiter
// Purpose  : Directed, table-driven bench for mux_rr_arbiter (MAX_HOLD=8)
//            with hand-written sequences for tenure cap, release priority
//            and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [5:0] i_req;
  logic       i_release;
  logic [5:0] i_data_in;
  logic [5:0] o_grant;
  logic [2:0] o_sel;
  logic       o_busy;
  logic       o_data_out;
  logic       o_timeout;

  int n_checks;
  int n_errors;

  mux_rr_arbiter #(.MAX_HOLD(8), .HOLD_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_release (i_release),
    .i_data_in (i_data_in),
    .o_grant   (o_grant),
    .o_sel     (o_sel),
    .o_busy    (o_busy),
    .o_data_out(o_data_out),
    .o_timeout (o_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] req;
    logic       rel;
    logic [5:0] din;
    int         reps;
    logic [5:0] g;
    logic [2:0] s;
    logic       b;
    logic       d;
    logic       t;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [5:0] g, input logic [2:0] s,
                         input logic b, input logic d, input logic t);
    chk({tag, ".grant"},   {2'b0, o_grant}, {2'b0, g});
    chk({tag, ".sel"},     {5'b0, o_sel},   {5'b0, s});
    chk({tag, ".busy"},    {7'b0, o_busy},  {7'b0, b});
    chk({tag, ".dout"},    {7'b0, o_data_out}, {7'b0, d});
    chk({tag, ".timeout"}, {7'b0, o_timeout},  {7'b0, t});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    clk       = 1'b0;
    rst       = 1'b0;
    i_req     = 6'b0;
    i_release = 1'b0;
    i_data_in = 6'b0;

    //            req        rel   din        reps grant      sel   busy  dout  to
    tbl[0] = '{6'b000100, 1'b0, 6'b000100, 1,  6'b000100, 3'd2, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{6'b000000, 1'b0, 6'b000000, 1,  6'b000000, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{6'b100001, 1'b0, 6'b100000, 1,  6'b100000, 3'd5, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{6'b100001, 1'b1, 6'b000001, 1,  6'b000001, 3'd0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{6'b100001, 1'b1, 6'b000001, 1,  6'b100000, 3'd5, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{6'b100001, 1'b1, 6'b000001, 1,  6'b000001, 3'd0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{6'b000000, 1'b0, 6'b000001, 1,  6'b000000, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{6'b001000, 1'b0, 6'b001000, 20, 6'b001000, 3'd3, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{6'b000000, 1'b0, 6'b001000, 1,  6'b000000, 3'd3, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{6'b000000, 1'b1, 6'b111111, 1,  6'b000000, 3'd3, 1'b0, 1'b0, 1'b0};

    // Reset state
    #1 rst = 1'b1;
    #1 chk_all("reset", 6'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single request, round-robin alternation, lone holder, idle release
    for (int v = 0; v < 10; v++) begin
      i_req     = tbl[v].req;
      i_release = tbl[v].rel;
      i_data_in = tbl[v].din;
      for (int r = 0; r < tbl[v].reps; r++) begin
        tick();
        chk_all($sformatf("vec%0d.%0d", v, r), tbl[v].g, tbl[v].s, tbl[v].b, tbl[v].d, tbl[v].t);
      end
    end

    // Tenure cap: last=3, so src0 wins first; 8 cycles each, then forced hand-over
    i_release = 1'b0;
    i_data_in = 6'b000010;
    i_req     = 6'b000011;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk_all($sformatf("cap0.%0d", c), 6'b000001, 3'd0, 1'b1, 1'b0, 1'b0);
    end
    tick();
    chk_all("cap_to1", 6'b000010, 3'd1, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 7; c++) begin
      tick();
      chk_all($sformatf("cap1.%0d", c), 6'b000010, 3'd1, 1'b1, 1'b1, 1'b0);
    end
    tick();
    chk_all("cap_to0", 6'b000001, 3'd0, 1'b1, 1'b0, 1'b1);
    i_req = 6'b0;
    tick();
    chk_all("cap_idle", 6'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Release coinciding with the cap: last=0, so src1 wins first
    i_req = 6'b000011;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk_all($sformatf("relcap.%0d", c), 6'b000010, 3'd1, 1'b1, 1'b1, 1'b0);
    end
    i_release = 1'b1;
    tick();
    chk_all("relcap_end", 6'b000001, 3'd0, 1'b1, 1'b0, 1'b0);
    i_release = 1'b0;
    i_req     = 6'b0;
    tick();
    chk_all("relcap_idle", 6'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-tenure: last=0, src1 is granted first
    i_req     = 6'b111111;
    i_data_in = 6'b111111;
    tick();
    chk_all("pre_rst", 6'b000010, 3'd1, 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 6'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    tick();
    chk_all("post_rst", 6'b000001, 3'd0, 1'b1, 1'b1, 1'b0);
    i_release = 1'b1;
    tick();
    chk_all("post_rst_next", 6'b000010, 3'd1, 1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
